bin_to_bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter (shift-add-3, "double dabble") driving the

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_add3.sv | 11 +
 rtl/bin_to_bcd_seq.sv | 144 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bcd_pkg;

  // Converter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Number of BCD digits produced; matches the three LED_driver digit inputs
  localparam int NDIG = 3;

  // Largest value representable in NDIG digits
  localparam int BCD_MAX = 999;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble adjust: a BCD nibble >= 5 gets +3 before the next shift.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter feeding LED_driver digits x0..x2.
// Latency: start in cycle 0 -> done and new digits in cycle W+1; accepts every W+2 cycles.
// Backpressure: start is dropped (not queued) while busy or in DONE; BCD_SAT_EN clamps overflow to 999.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic [3:0]   x0,
  output logic [3:0]   x1,
  output logic [3:0]   x2
);

  localparam int CW = $clog2(W + 1);
  localparam int AW = 4 * NDIG + 1;   // accumulator keeps the carry into thousands

  state_e          state_q, state_d;
  logic [W-1:0]    sreg_q, sreg_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            big_q, big_d;      // sampled bin already exceeds BCD_MAX
  logic            load;

  logic [AW-1:0]   adj;
  logic [AW+W-1:0] cat_sh;
  logic [AW-1:0]   acc_sh;
  logic [W-1:0]    sreg_sh;
  logic            ovf_d;
  logic [4*NDIG-1:0] dig_d;

  logic            done_q, ovf_q;
  logic [3:0]      x0_q, x1_q, x2_q;

  // Add-3 adjust on each BCD nibble; the thousands carry bit passes through
  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_add3 u_add3 (
      .nib_i (acc_q[4*g +: 4]),
      .nib_o (adj[4*g +: 4])
    );
  end
  assign adj[AW-1] = acc_q[AW-1];

  // One double-dabble step: shift {adjusted acc, sreg} left by one
  assign cat_sh  = {adj[AW-2:0], sreg_q, 1'b0};
  assign acc_sh  = cat_sh[AW+W-1 -: AW];
  assign sreg_sh = cat_sh[W-1:0];

  // Result selection from the final shifted accumulator
  always_comb begin
    ovf_d = acc_sh[AW-1] | big_q;
`ifdef BCD_SAT_EN
    dig_d = ovf_d ? {NDIG{4'h9}} : acc_sh[4*NDIG-1:0];
`else
    dig_d = acc_sh[4*NDIG-1:0];
`endif
  end

  // Next-state logic: capture on start, W shift steps, one DONE cycle
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    big_d   = big_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d  = bin;
          acc_d   = '0;
          cnt_d   = CW'(W);
          big_d   = (32'(bin) > 32'(BCD_MAX));
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = sreg_sh;
        acc_d  = acc_sh;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          load    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Conversion datapath and FSM state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      big_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      big_q   <= big_d;
    end
  end

  // Displayed digits change only when entering DONE, so partial values never show
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      x0_q   <= 4'h0;
      x1_q   <= 4'h0;
      x2_q   <= 4'h0;
    end else begin
      done_q <= load;
      if (load) begin
        ovf_q <= ovf_d;
        x0_q  <= dig_d[3:0];
        x1_q  <= dig_d[7:4];
        x2_q  <= dig_d[11:8];
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign x0   = x0_q;
  assign x1   = x1_q;
  assign x2   = x2_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against a decimal-arithmetic reference.
// Latency: expects done exactly W+1 cycles after the start cycle.
// Backpressure: exercises start while busy and in DONE; honours BCD_SAT_EN in the model.
module tb_bin_to_bcd_seq;

  localparam int W = 10;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] bin = '0;
  logic         busy, done, ovf;
  logic [3:0]   x0, x1, x2;

  int n_vec = 0;
  int n_err = 0;

  bin_to_bcd_seq #(.W(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .x0      (x0),
    .x1      (x1),
    .x2      (x2)
  );

  always #5 clock = ~clock;

  // Reference: {ovf, hundreds, tens, units} from plain decimal arithmetic
  function automatic logic [12:0] model(input int v);
    int  d;
    logic o;
    o = (v > 999);
`ifdef BCD_SAT_EN
    d = o ? 999 : v;
`else
    d = v % 1000;
`endif
    return {o, 4'(d / 100), 4'(d / 10 % 10), 4'(d % 10)};
  endfunction

  // One conversion from the next cycle; bin is scrambled while busy
  task automatic convert(input int v, output int lat, output logic [12:0] got,
                         output bit unstable);
    logic [11:0] prev;
    lat = -1;
    unstable = 1'b0;
    @(posedge clock); #1;
    prev  = {x2, x1, x0};
    start = 1'b1;
    bin   = W'(v);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      start = 1'b0;
      bin   = W'($urandom);
      if (done) begin
        lat = c;
        break;
      end
      if ({x2, x1, x0} !== prev) unstable = 1'b1;
    end
    got = {ovf, x2, x1, x0};
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #3;
    n_vec++;
    if ({busy, done, ovf, x2, x1, x0} !== 15'h0) begin
      n_err++;
      $display("FAIL reset_state got=%h want=0", {busy, done, ovf, x2, x1, x0});
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat; logic [12:0] got; bit uns;
    convert(108, lat, got, uns);
    n_vec++;
    if (lat !== W + 1) begin
      n_err++; $display("FAIL basic_latency got=%0d want=%0d", lat, W + 1);
    end
    n_vec++;
    if (got !== 13'h0108) begin
      n_err++; $display("FAIL basic_108 got=%h want=%h", got, 13'h0108);
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL basic_busy_in_done got=%b want=1", busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [12:0] got; bit uns;
    convert(0, lat, got, uns);
    n_vec++;
    if (got !== model(0) || lat !== W + 1) begin
      n_err++; $display("FAIL b2b_first got=%h lat=%0d want=%h lat=%0d", got, lat, model(0), W + 1);
    end
    convert(999, lat, got, uns);
    n_vec++;
    if (got !== 13'h0999 || lat !== W + 1) begin
      n_err++; $display("FAIL b2b_second got=%h lat=%0d want=%h lat=%0d", got, lat, 13'h0999, W + 1);
    end
  endtask

  task automatic test_busy_start;
    int ndone = 0;
    logic [12:0] got = '0;
    @(posedge clock); #1;
    start = 1'b1;
    bin   = W'(200);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (c == 3) begin start = 1'b1; bin = W'(555); end
      if (done) begin
        ndone++;
        got   = {ovf, x2, x1, x0};
        start = 1'b1;
        bin   = W'(555);
      end
    end
    n_vec++;
    if (ndone !== 1) begin
      n_err++; $display("FAIL busy_start_done_count got=%0d want=1", ndone);
    end
    n_vec++;
    if (got !== model(200)) begin
      n_err++; $display("FAIL busy_start_result got=%h want=%h", got, model(200));
    end
    n_vec++;
    if ({busy, ovf, x2, x1, x0} !== {1'b0, model(200)}) begin
      n_err++; $display("FAIL busy_start_final got=%h want=%h", {busy, ovf, x2, x1, x0}, {1'b0, model(200)});
    end
  endtask

  task automatic test_overflow;
    int lat; logic [12:0] got; bit uns;
    int vals[4];
    vals[0] = 1023; vals[1] = 1000;
    vals[2] = int'($urandom_range(1000, 1023)); vals[3] = 998;
    foreach (vals[i]) begin
      convert(vals[i], lat, got, uns);
      n_vec++;
      if (got !== model(vals[i])) begin
        n_err++; $display("FAIL overflow bin=%0d got=%h want=%h", vals[i], got, model(vals[i]));
      end
    end
  endtask

  task automatic test_random;
    int lat; logic [12:0] got; bit uns; int v;
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 1023));
      convert(v, lat, got, uns);
      n_vec++;
      if (got !== model(v) || lat !== W + 1 || uns) begin
        n_err++;
        $display("FAIL random bin=%0d got=%h lat=%0d unstable=%0d want=%h lat=%0d unstable=0",
                 v, got, lat, uns, model(v), W + 1);
      end
    end
  endtask

  task automatic test_sweep;
    int lat; logic [12:0] got; bit uns;
    for (int v = 0; v <= 999; v++) begin
      convert(v, lat, got, uns);
      n_vec++;
      if (got !== model(v) || lat !== W + 1 || uns) begin
        n_err++;
        $display("FAIL sweep bin=%0d got=%h lat=%0d unstable=%0d want=%h lat=%0d unstable=0",
                 v, got, lat, uns, model(v), W + 1);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [12:0] got; bit uns;
    int ndone = 0;
    int nbusy = 0;
    convert(108, lat, got, uns);
    @(posedge clock); #1;
    start = 1'b1;
    bin   = W'(777);
    repeat (4) begin
      @(posedge clock); #1;
      start = 1'b0;
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_busy_before got=%b want=1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, ovf, x2, x1, x0} !== 15'h0) begin
      n_err++; $display("FAIL reset_mid_outputs got=%h want=0", {busy, done, ovf, x2, x1, x0});
    end
    @(posedge clock); #1 reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    n_vec++;
    if (ndone !== 0 || nbusy !== 0 || {x2, x1, x0} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_mid_after dones=%0d busy_cycles=%0d digits=%h want 0 0 000",
               ndone, nbusy, {x2, x1, x0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_busy_start();
    test_overflow();
    test_random();
    test_sweep();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
